sevenseg_scan_decoder: RTL and testbench

- Reverse direction of the hex-to-seven-segment path: observes a multiplexed, inverted-logic seven-segment display bus (segment lines plus per-digit strobes).
- Waits for each digit's pattern to settle, then decodes it back to a 4-bit hex value and stores it per digit.
- Used by board self-test and by the lab checker to read back what the display logic is driving.

---
 rtl/sevenseg_pkg.sv | 37 +++
 rtl/sevenseg2hex.sv | 40 ++++
 rtl/sevenseg_scan_decoder.sv | 168 ++++++++++++++++
 tb/tb_sevenseg_scan_decoder.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// Shared glyph table and FSM state type for the seven-segment read-back path.
// Codes are {g,f,e,d,c,b,a} with 1 = segment lit.
package sevenseg_pkg;

  localparam int unsigned SEG_BIT_A = 0;
  localparam int unsigned SEG_BIT_B = 1;
  localparam int unsigned SEG_BIT_C = 2;
  localparam int unsigned SEG_BIT_D = 3;
  localparam int unsigned SEG_BIT_E = 4;
  localparam int unsigned SEG_BIT_F = 5;
  localparam int unsigned SEG_BIT_G = 6;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StHold
  } scan_state_e;

endpackage

// File: rtl/sevenseg2hex.sv
// Combinational seven-segment code to hex decoder; flags blank and illegal codes.
module sevenseg2hex
  import sevenseg_pkg::*;
(
  input  logic [6:0] code_i,
  output logic       legal_o,
  output logic       blank_o,
  output logic [3:0] hex_o
);

  always_comb begin
    legal_o = 1'b1;
    blank_o = 1'b0;
    hex_o   = 4'h0;
    case (code_i)
      SEG_0:     hex_o = 4'h0;
      SEG_1:     hex_o = 4'h1;
      SEG_2:     hex_o = 4'h2;
      SEG_3:     hex_o = 4'h3;
      SEG_4:     hex_o = 4'h4;
      SEG_5:     hex_o = 4'h5;
      SEG_6:     hex_o = 4'h6;
      SEG_7:     hex_o = 4'h7;
      SEG_8:     hex_o = 4'h8;
      SEG_9:     hex_o = 4'h9;
      SEG_A:     hex_o = 4'hA;
      SEG_B:     hex_o = 4'hB;
      SEG_C:     hex_o = 4'hC;
      SEG_D:     hex_o = 4'hD;
      SEG_E:     hex_o = 4'hE;
      SEG_F:     hex_o = 4'hF;
      SEG_BLANK: begin
        legal_o = 1'b0;
        blank_o = 1'b1;
      end
      default:   legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/sevenseg_scan_decoder.sv
// Observes a multiplexed active-low seven-segment bus, waits for each digit to settle
// and stores the decoded hex value per digit slot.
module sevenseg_scan_decoder
  import sevenseg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned SETTLE_CYCLES = 4,
  localparam int unsigned IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    SEG_A,
  input  logic                    SEG_B,
  input  logic                    SEG_C,
  input  logic                    SEG_D,
  input  logic                    SEG_E,
  input  logic                    SEG_F,
  input  logic                    SEG_G,
  input  logic [NUM_DIGITS-1:0]   DIGIT_N,
  output logic [4*NUM_DIGITS-1:0] HEX_OUT,
  output logic [NUM_DIGITS-1:0]   DIGIT_VALID,
  output logic [NUM_DIGITS-1:0]   PATTERN_ERR,
  output logic                    UPDATE,
  output logic [IDX_W-1:0]        UPDATE_IDX,
  output logic                    STROBE_ERR
);

  localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(SETTLE_CYCLES - 1);

  logic [6:0] seg_raw;
  logic [6:0] s_seg_q, p_seg_q;
  logic [NUM_DIGITS-1:0] s_str_q, p_str_q;
  scan_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic serr_done_q, serr_done_d;
  logic [4*NUM_DIGITS-1:0] hex_q;
  logic [NUM_DIGITS-1:0] valid_q, perr_q;
  logic update_q, strobe_err_q;
  logic [IDX_W-1:0] update_idx_q, str_idx;
  logic change, str_none, str_one, str_multi;
  logic capture, serr_fire;
  logic dec_legal, dec_blank;
  logic [3:0] dec_hex;

  always_comb begin
    seg_raw            = '0;
    seg_raw[SEG_BIT_A] = SEG_A;
    seg_raw[SEG_BIT_B] = SEG_B;
    seg_raw[SEG_BIT_C] = SEG_C;
    seg_raw[SEG_BIT_D] = SEG_D;
    seg_raw[SEG_BIT_E] = SEG_E;
    seg_raw[SEG_BIT_F] = SEG_F;
    seg_raw[SEG_BIT_G] = SEG_G;
  end

  assign change    = ({s_seg_q, s_str_q} != {p_seg_q, p_str_q});
  assign str_none  = (s_str_q == '0);
  assign str_one   = $onehot(s_str_q);
  assign str_multi = !str_none && !str_one;

  always_comb begin
    str_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (s_str_q[i]) str_idx = IDX_W'(i);
    end
  end

  sevenseg2hex u_dec (
    .code_i  (s_seg_q),
    .legal_o (dec_legal),
    .blank_o (dec_blank),
    .hex_o   (dec_hex)
  );

  // The counter is shared: in StSettle it times a capture, in StIdle it times the
  // one-shot strobe error for a stable multi-strobe sample.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    serr_done_d = serr_done_q;
    capture     = 1'b0;
    serr_fire   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (change) begin
          cnt_d       = '0;
          serr_done_d = 1'b0;
          if (str_one) state_d = StSettle;
        end else if (str_multi && !serr_done_q) begin
          if (cnt_q == CntLast) begin
            serr_fire   = 1'b1;
            serr_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StSettle: begin
        if (change) begin
          cnt_d       = '0;
          serr_done_d = 1'b0;
          if (!str_one) state_d = StIdle;
        end else if (cnt_q == CntLast) begin
          capture = 1'b1;
          state_d = StHold;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHold: begin
        if (change) begin
          cnt_d       = '0;
          serr_done_d = 1'b0;
          state_d     = str_one ? StSettle : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      s_seg_q      <= '0;
      s_str_q      <= '0;
      p_seg_q      <= '0;
      p_str_q      <= '0;
      state_q      <= StIdle;
      cnt_q        <= '0;
      serr_done_q  <= 1'b0;
      hex_q        <= '0;
      valid_q      <= '0;
      perr_q       <= '0;
      update_q     <= 1'b0;
      update_idx_q <= '0;
      strobe_err_q <= 1'b0;
    end else begin
      s_seg_q      <= ~seg_raw;
      s_str_q      <= ~DIGIT_N;
      p_seg_q      <= s_seg_q;
      p_str_q      <= s_str_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      serr_done_q  <= serr_done_d;
      update_q     <= capture;
      strobe_err_q <= serr_fire;
      if (capture) begin
        update_idx_q <= str_idx;
        if (dec_legal) begin
          hex_q[{str_idx, 2'b00} +: 4] <= dec_hex;
          valid_q[str_idx]             <= 1'b1;
          perr_q[str_idx]              <= 1'b0;
        end else begin
          valid_q[str_idx] <= 1'b0;
          perr_q[str_idx]  <= !dec_blank;
        end
      end
    end
  end

  assign HEX_OUT     = hex_q;
  assign DIGIT_VALID = valid_q;
  assign PATTERN_ERR = perr_q;
  assign UPDATE      = update_q;
  assign UPDATE_IDX  = update_idx_q;
  assign STROBE_ERR  = strobe_err_q;

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Self-checking bench for sevenseg_scan_decoder: directed scenarios plus a randomized
// scan checked against a glyph-table model of the digit slots.
module tb_sevenseg_scan_decoder;

  localparam int ND = 4;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F, SEG_G;
  logic [ND-1:0] DIGIT_N;
  logic [4*ND-1:0] HEX_OUT;
  logic [ND-1:0] DIGIT_VALID, PATTERN_ERR;
  logic          UPDATE, STROBE_ERR;
  logic [1:0]    UPDATE_IDX;

  always #5 CLK = ~CLK;

  sevenseg_scan_decoder #(
    .NUM_DIGITS    (ND),
    .SETTLE_CYCLES (4)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .SEG_A       (SEG_A),
    .SEG_B       (SEG_B),
    .SEG_C       (SEG_C),
    .SEG_D       (SEG_D),
    .SEG_E       (SEG_E),
    .SEG_F       (SEG_F),
    .SEG_G       (SEG_G),
    .DIGIT_N     (DIGIT_N),
    .HEX_OUT     (HEX_OUT),
    .DIGIT_VALID (DIGIT_VALID),
    .PATTERN_ERR (PATTERN_ERR),
    .UPDATE      (UPDATE),
    .UPDATE_IDX  (UPDATE_IDX),
    .STROBE_ERR  (STROBE_ERR)
  );

  int checks = 0;
  int errors = 0;

  logic [6:0]  glyph [16];
  logic [15:0] exp_hex;
  logic [3:0]  exp_valid, exp_perr;

  int         first_upd, upd_cnt, serr_cnt, first_serr;
  logic [1:0] last_idx;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply(input logic [3:0] dn, input logic [6:0] code);
    {SEG_G, SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A} = ~code;
    DIGIT_N = dn;
  endtask

  // Clock n edges, recording UPDATE and STROBE_ERR activity (tick numbers start at 1).
  task automatic watch(input int n);
    first_upd  = 0;
    upd_cnt    = 0;
    serr_cnt   = 0;
    first_serr = 0;
    for (int t = 1; t <= n; t++) begin
      tick();
      if (UPDATE === 1'b1) begin
        upd_cnt++;
        if (first_upd == 0) first_upd = t;
        last_idx = UPDATE_IDX;
      end
      if (STROBE_ERR === 1'b1) begin
        serr_cnt++;
        if (first_serr == 0) first_serr = t;
      end
    end
  endtask

  // Slot model: a settled code on digit d becomes a hex value, a blank, or an error.
  task automatic model_capture(input int d, input logic [6:0] code);
    int v;
    v = -1;
    for (int k = 0; k < 16; k++) if (glyph[k] == code) v = k;
    if (v >= 0) begin
      exp_hex[4*d +: 4] = 4'(v);
      exp_valid[d]      = 1'b1;
      exp_perr[d]       = 1'b0;
    end else begin
      exp_valid[d] = 1'b0;
      exp_perr[d]  = (code != 7'h00);
    end
  endtask

  task automatic model_reset();
    exp_hex   = '0;
    exp_valid = '0;
    exp_perr  = '0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    apply(4'($urandom), 7'($urandom));
    tick();
    apply(4'($urandom), 7'($urandom));
    tick();
    model_reset();
    checks++;
    if (HEX_OUT !== 16'h0) begin
      errors++; $display("FAIL reset_hex: got %h expected 0000", HEX_OUT);
    end
    checks++;
    if (DIGIT_VALID !== 4'h0 || PATTERN_ERR !== 4'h0) begin
      errors++; $display("FAIL reset_flags: got valid=%b perr=%b expected 0000/0000",
                         DIGIT_VALID, PATTERN_ERR);
    end
    checks++;
    if (UPDATE !== 1'b0 || UPDATE_IDX !== 2'd0 || STROBE_ERR !== 1'b0) begin
      errors++; $display("FAIL reset_pulses: got upd=%b idx=%0d serr=%b expected 0/0/0",
                         UPDATE, UPDATE_IDX, STROBE_ERR);
    end
    RESET = 1'b0;
    apply(4'hF, 7'($urandom));
    watch(20);
    checks++;
    if (upd_cnt !== 0 || serr_cnt !== 0) begin
      errors++; $display("FAIL no_strobe_idle: got upd=%0d serr=%0d expected 0/0",
                         upd_cnt, serr_cnt);
    end
  endtask

  task automatic test_single_digit();
    apply(4'b1110, glyph[2]);
    watch(10);
    model_capture(0, glyph[2]);
    checks++;
    if (upd_cnt !== 1 || first_upd !== 6) begin
      errors++; $display("FAIL single_latency: got count=%0d tick=%0d expected 1/6",
                         upd_cnt, first_upd);
    end
    checks++;
    if (last_idx !== 2'd0) begin
      errors++; $display("FAIL single_idx: got %0d expected 0", last_idx);
    end
    checks++;
    if (HEX_OUT[3:0] !== 4'h2 || DIGIT_VALID !== 4'b0001) begin
      errors++; $display("FAIL single_value: got hex=%h valid=%b expected 2/0001",
                         HEX_OUT[3:0], DIGIT_VALID);
    end
  endtask

  task automatic test_full_scan();
    int vals [4];
    vals = '{3, 10, 12, 15};
    for (int d = 0; d < 4; d++) begin
      apply(4'(~(4'b0001 << d)), glyph[vals[d]]);
      watch(8);
      model_capture(d, glyph[vals[d]]);
      checks++;
      if (upd_cnt !== 1 || last_idx !== 2'(d)) begin
        errors++; $display("FAIL scan_update_%0d: got count=%0d idx=%0d expected 1/%0d",
                           d, upd_cnt, last_idx, d);
      end
    end
    checks++;
    if (HEX_OUT !== 16'hFCA3 || DIGIT_VALID !== 4'b1111) begin
      errors++; $display("FAIL scan_result: got hex=%h valid=%b expected fca3/1111",
                         HEX_OUT, DIGIT_VALID);
    end
  endtask

  task automatic test_glitch();
    int total;
    apply(4'b1101, 7'h06);
    watch(2);
    total = upd_cnt;
    apply(4'b1101, 7'h07);
    watch(10);
    total += upd_cnt;
    model_capture(1, 7'h07);
    checks++;
    if (total !== 1 || first_upd !== 6) begin
      errors++; $display("FAIL glitch_updates: got count=%0d tick=%0d expected 1/6",
                         total, first_upd);
    end
    checks++;
    if (HEX_OUT !== exp_hex || HEX_OUT[7:4] !== 4'h7) begin
      errors++; $display("FAIL glitch_value: got %h expected %h", HEX_OUT, exp_hex);
    end
  endtask

  task automatic test_bad_glyph();
    apply(4'b1011, 7'h01);
    watch(8);
    model_capture(2, 7'h01);
    checks++;
    if (PATTERN_ERR !== 4'b0100 || DIGIT_VALID !== exp_valid || HEX_OUT !== exp_hex) begin
      errors++; $display("FAIL bad_glyph: got perr=%b valid=%b hex=%h expected 0100/%b/%h",
                         PATTERN_ERR, DIGIT_VALID, HEX_OUT, exp_valid, exp_hex);
    end
    // Make digit 2 valid again so the blank visibly clears DIGIT_VALID[2].
    apply(4'b1011, glyph[9]);
    watch(8);
    model_capture(2, glyph[9]);
    apply(4'b1011, 7'h00);
    watch(8);
    model_capture(2, 7'h00);
    checks++;
    if (PATTERN_ERR !== 4'b0000 || DIGIT_VALID !== 4'b1011 || HEX_OUT !== exp_hex) begin
      errors++; $display("FAIL blank: got perr=%b valid=%b hex=%h expected 0000/1011/%h",
                         PATTERN_ERR, DIGIT_VALID, HEX_OUT, exp_hex);
    end
  endtask

  task automatic test_multi_strobe();
    apply(4'b1100, glyph[$urandom_range(0, 15)]);
    watch(6);
    checks++;
    if (serr_cnt !== 1 || first_serr !== 6 || upd_cnt !== 0) begin
      errors++; $display("FAIL multi_strobe: got serr=%0d tick=%0d upd=%0d expected 1/6/0",
                         serr_cnt, first_serr, upd_cnt);
    end
    watch(12);
    checks++;
    if (serr_cnt !== 0 || upd_cnt !== 0 || HEX_OUT !== exp_hex) begin
      errors++; $display("FAIL multi_repeat: got serr=%0d upd=%0d hex=%h expected 0/0/%h",
                         serr_cnt, upd_cnt, HEX_OUT, exp_hex);
    end
  endtask

  task automatic test_reset_mid_settle();
    apply(4'b0111, glyph[5]);
    watch(4);
    RESET = 1'b1;
    tick();
    model_reset();
    checks++;
    if (upd_cnt !== 0 || UPDATE !== 1'b0 || HEX_OUT !== 16'h0 || DIGIT_VALID !== 4'h0) begin
      errors++; $display("FAIL mid_settle_reset: got upd=%0d/%b hex=%h valid=%b expected 0",
                         upd_cnt, UPDATE, HEX_OUT, DIGIT_VALID);
    end
    RESET = 1'b0;
    watch(10);
    model_capture(3, glyph[5]);
    checks++;
    if (upd_cnt !== 1 || first_upd !== 6 || last_idx !== 2'd3) begin
      errors++; $display("FAIL post_reset_settle: got count=%0d tick=%0d idx=%0d expected 1/6/3",
                         upd_cnt, first_upd, last_idx);
    end
    checks++;
    if (HEX_OUT !== exp_hex || DIGIT_VALID !== exp_valid) begin
      errors++; $display("FAIL post_reset_value: got hex=%h valid=%b expected %h/%b",
                         HEX_OUT, DIGIT_VALID, exp_hex, exp_valid);
    end
  endtask

  task automatic test_random_scan();
    int         d;
    logic [6:0] code;
    for (int it = 0; it < 24; it++) begin
      d = $urandom_range(0, 3);
      code = ($urandom_range(0, 3) == 0) ? 7'($urandom) : glyph[$urandom_range(0, 15)];
      apply(4'hF, 7'h00);
      watch(2);
      apply(4'(~(4'b0001 << d)), code);
      watch(8);
      model_capture(d, code);
      checks++;
      if (upd_cnt !== 1 || first_upd !== 6 || last_idx !== 2'(d)) begin
        errors++; $display("FAIL rand_update_%0d: got count=%0d tick=%0d idx=%0d expected 1/6/%0d",
                           it, upd_cnt, first_upd, last_idx, d);
      end
      checks++;
      if (HEX_OUT !== exp_hex || DIGIT_VALID !== exp_valid || PATTERN_ERR !== exp_perr) begin
        errors++; $display("FAIL rand_slots_%0d: got %h/%b/%b expected %h/%b/%b (code %h)",
                           it, HEX_OUT, DIGIT_VALID, PATTERN_ERR,
                           exp_hex, exp_valid, exp_perr, code);
      end
    end
  endtask

  initial begin
    glyph = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    RESET = 1'b1;
    apply(4'hF, 7'h00);
    model_reset();
    test_reset();
    test_single_digit();
    test_full_scan();
    test_glitch();
    test_bad_glyph();
    test_multi_strobe();
    test_reset_mid_settle();
    test_random_scan();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
